// File: rtl/vdp_irq_ctrl.sv
// vdp_irq_ctrl
//   VDP interrupt controller. It raises the frame (vertical blank) interrupt
//   and a reloadable down-counting line interrupt. It also collects NUM_EXT
//   sticky status sources, such as sprite overflow and collision. It presents
//   the status byte and the active-low CPU interrupt. A control-port status
//   read (stat_rd) acknowledges every pending flag.
//
// Optional feature macro: VDP_IRQ_EXT_INT_EN
//   When defined, any pending external flag also pulls int_l low. There is no
//   separate enable for this. When undefined, the external flags only appear in
//   the status byte.
//
// Ports
//   clk          block clock; every register is clocked on its rising edge
//   rst          synchronous active-high reset
//   line_start   one-cycle pulse at the start of each scanline
//   line_num     current scanline, 0 = first active line; qualified by line_start
//   line_reload  line interrupt reload value (register 10)
//   line_ie      line interrupt enable (register 0 bit 4)
//   frame_ie     frame interrupt enable (register 1 bit 5)
//   ext_set      per-source sticky set pulses
//   stat_rd      status read pulse; acknowledges all flags
//   status_out   {frame, ext[0], ext[1], ..., 0...}
//   int_l        interrupt request to the CPU, active low
//   line_pending line interrupt flag
//   line_cnt     current line counter value (debug)
module vdp_irq_ctrl #(
  parameter int unsigned LINE_W       = 8,
  parameter int unsigned ROW_W        = 9,
  parameter int unsigned ACTIVE_LINES = 192,
  parameter int unsigned NUM_EXT      = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  line_start,
  input  logic [ROW_W-1:0]                      line_num,
  input  logic [LINE_W-1:0]                     line_reload,
  input  logic                                  line_ie,
  input  logic                                  frame_ie,
  input  logic [((NUM_EXT > 0) ? NUM_EXT : 1)-1:0] ext_set,
  input  logic                                  stat_rd,
  output logic [7:0]                            status_out,
  output logic                                  int_l,
  output logic                                  line_pending,
  output logic [LINE_W-1:0]                     line_cnt
);

  // With no external sources, a single unused bit keeps the vectors legal.
  // That bit is never routed to an output.
  localparam int unsigned     EXT_W   = (NUM_EXT > 0) ? NUM_EXT : 1;
  localparam logic [ROW_W-1:0] ACT_ROW = ROW_W'(ACTIVE_LINES);

  logic              frame_flag;
  logic              line_flag;
  logic [EXT_W-1:0]  ext_flag;
  logic [LINE_W-1:0] cnt;

  logic              in_active;
  logic              cnt_zero;
  logic              line_set;
  logic              frame_set;
  logic [6:0]        ext_vec;
  logic              irq;

  // The active window includes the line where line_num == ACTIVE_LINES. That
  // line counts like any other active line, and it is also the frame event line.
  assign in_active = (line_num <= ACT_ROW);
  assign cnt_zero  = (cnt == '0);
  assign line_set  = line_start & in_active & cnt_zero;
  assign frame_set = line_start & (line_num == ACT_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '1;
      frame_flag <= 1'b0;
      line_flag  <= 1'b0;
      ext_flag   <= '0;
    end else begin
      if (line_start) begin
        // Outside the active window the counter is held at the reload value.
        // At zero it reloads instead of wrapping.
        if (!in_active || cnt_zero) cnt <= line_reload;
        else                        cnt <= cnt - LINE_W'(1);
      end
      // The set term is ORed after the clear, so a set in the same cycle as
      // an acknowledge leaves the flag at 1.
      frame_flag <= frame_set | (frame_flag & ~stat_rd);
      line_flag  <= line_set  | (line_flag  & ~stat_rd);
      ext_flag   <= ext_set   | (ext_flag   & ~{EXT_W{stat_rd}});
    end
  end

  // ext_flag[i] is reported on status bit (6-i). Unused bits read as 0.
  for (genvar g = 0; g < 7; g++) begin : g_ext
    if (g < NUM_EXT) begin : g_on
      assign ext_vec[6-g] = ext_flag[g];
    end else begin : g_off
      assign ext_vec[6-g] = 1'b0;
    end
  end

`ifdef VDP_IRQ_EXT_INT_EN
  assign irq = (frame_flag & frame_ie) | (line_flag & line_ie) | (|ext_vec);
`else
  assign irq = (frame_flag & frame_ie) | (line_flag & line_ie);
`endif

  assign status_out   = {frame_flag, ext_vec};
  assign int_l        = ~irq;
  assign line_pending = line_flag;
  assign line_cnt     = cnt;

endmodule

// File: tb/tb_vdp_irq_ctrl.sv
// Testbench for vdp_irq_ctrl. A behavioural model of the flags and the line
// counter is stepped at each rising edge from the same inputs the DUT sees.
// Directed scenarios are followed by a randomized run.
module tb_vdp_irq_ctrl;
  localparam int LINE_W = 8;
  localparam int ROW_W  = 9;
  localparam int ACT    = 192;
  localparam int NEXT   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              line_start = 1'b0;
  logic [ROW_W-1:0]  line_num = '0;
  logic [LINE_W-1:0] line_reload = '0;
  logic              line_ie = 1'b0;
  logic              frame_ie = 1'b0;
  logic [NEXT-1:0]   ext_set = '0;
  logic              stat_rd = 1'b0;
  logic [7:0]        status_out;
  logic              int_l;
  logic              line_pending;
  logic [LINE_W-1:0] line_cnt;

  int nchk = 0;
  int nerr = 0;

  // Reference model state
  int m_cnt;
  bit m_frame, m_line;
  bit m_ext[NEXT];

  vdp_irq_ctrl #(.LINE_W(LINE_W), .ROW_W(ROW_W), .ACTIVE_LINES(ACT), .NUM_EXT(NEXT)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_num(line_num),
    .line_reload(line_reload), .line_ie(line_ie), .frame_ie(frame_ie),
    .ext_set(ext_set), .stat_rd(stat_rd), .status_out(status_out),
    .int_l(int_l), .line_pending(line_pending), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_status();
    int v;
    v = m_frame ? 128 : 0;
    for (int i = 0; i < NEXT; i++) if (m_ext[i]) v += (1 << (6 - i));
    return 8'(v);
  endfunction

  function automatic logic exp_int_l();
    bit req;
    req = (m_frame && frame_ie) || (m_line && line_ie);
`ifdef VDP_IRQ_EXT_INT_EN
    for (int i = 0; i < NEXT; i++) if (m_ext[i]) req = 1;
`endif
    return !req;
  endfunction

  // Advance the model by one clock edge, using the inputs sampled at that edge.
  task automatic model_step();
    bit nf, nl;
    bit ne[NEXT];
    if (rst) begin
      m_cnt = (1 << LINE_W) - 1;
      m_frame = 0; m_line = 0;
      for (int i = 0; i < NEXT; i++) m_ext[i] = 0;
      return;
    end
    nf = m_frame && !stat_rd;
    nl = m_line && !stat_rd;
    for (int i = 0; i < NEXT; i++) ne[i] = (m_ext[i] && !stat_rd) || ext_set[i];
    if (line_start) begin
      if (int'(line_num) <= ACT) begin
        if (m_cnt == 0) begin m_cnt = int'(line_reload); nl = 1; end
        else m_cnt = m_cnt - 1;
      end else begin
        m_cnt = int'(line_reload);
      end
      if (int'(line_num) == ACT) nf = 1;
    end
    m_frame = nf; m_line = nl;
    for (int i = 0; i < NEXT; i++) m_ext[i] = ne[i];
  endtask

  // Apply inputs at the falling edge, clock them in, then drop the pulses.
  // Returns #1 after the rising edge, when the outputs are settled.
  task automatic cyc(input bit ls, input int ln, input logic [NEXT-1:0] es, input bit rd);
    @(negedge clk);
    line_start = ls; line_num = ROW_W'(ln); ext_set = es; stat_rd = rd;
    @(posedge clk);
    model_step();
    #1;
    line_start = 0; ext_set = '0; stat_rd = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) cyc(1, 192, 2'b11, 1);
    @(negedge clk);
    rst = 0;
    #1;
    if (line_cnt !== 8'hFF) begin nerr++; $display("FAIL reset_cnt: got %h exp ff", line_cnt); end
    nchk++;
    if (status_out !== 8'h00) begin nerr++; $display("FAIL reset_status: got %h exp 00", status_out); end
    nchk++;
    if (int_l !== 1'b1) begin nerr++; $display("FAIL reset_int_l: got %b exp 1", int_l); end
    nchk++;
    if (line_pending !== 1'b0) begin nerr++; $display("FAIL reset_line_pending: got %b exp 0", line_pending); end
    nchk++;
  endtask

  task automatic test_line_irq();
    line_reload = 8'd2; line_ie = 1; frame_ie = 0;
    cyc(0, 0, '0, 1);
    cyc(1, 200, '0, 0);
    if (line_cnt !== 8'd2) begin nerr++; $display("FAIL line_reload_200: got %0d exp 2", line_cnt); end
    nchk++;
    for (int ln = 0; ln < 10; ln++) begin
      cyc(1, ln, '0, 0);
      if (line_pending !== ((ln % 3) == 2)) begin
        nerr++; $display("FAIL line_flag ln=%0d: got %b exp %b", ln, line_pending, (ln % 3) == 2);
      end
      nchk++;
      if (int_l !== exp_int_l() || line_cnt !== LINE_W'(m_cnt)) begin
        nerr++; $display("FAIL line_int_l ln=%0d: got int_l=%b cnt=%0d exp int_l=%b cnt=%0d", ln, int_l, line_cnt, exp_int_l(), m_cnt);
      end
      nchk++;
      if (line_pending) begin
        cyc(0, 0, '0, 1);
        if (int_l !== 1'b1 || line_pending !== 1'b0) begin
          nerr++; $display("FAIL line_ack ln=%0d: got int_l=%b pend=%b exp 1/0", ln, int_l, line_pending);
        end
        nchk++;
      end
    end
  endtask

  task automatic test_frame();
    frame_ie = 1; line_ie = 0; line_reload = 8'(8'($urandom_range(0, 20)));
    cyc(0, 0, '0, 1);
    for (int ln = 0; ln < 262; ln++) begin
      cyc(1, ln, '0, 0);
      if (status_out !== ((ln >= ACT) ? 8'h80 : 8'h00) || int_l !== (ln < ACT)) begin
        nerr++; $display("FAIL frame ln=%0d: got status=%h int_l=%b exp status=%h int_l=%b", ln, status_out, int_l, (ln >= ACT) ? 8'h80 : 8'h00, ln < ACT);
      end
      nchk++;
      if (line_cnt !== LINE_W'(m_cnt) || line_pending !== m_line) begin
        nerr++; $display("FAIL frame_cnt ln=%0d: got cnt=%0d pend=%b exp cnt=%0d pend=%b", ln, line_cnt, line_pending, m_cnt, m_line);
      end
      nchk++;
    end
    cyc(0, 0, '0, 1);
    if (status_out !== 8'h00 || int_l !== 1'b1) begin
      nerr++; $display("FAIL frame_ack: got status=%h int_l=%b exp 00/1", status_out, int_l);
    end
    nchk++;
  endtask

  task automatic test_simultaneous();
    frame_ie = 0; line_ie = 0;
    cyc(0, 0, '0, 1);
    cyc(0, 0, 2'b10, 0);
    // Acknowledge together with the frame event and ext_set[0]. The status
    // read during this cycle must still show the pre-clear value.
    @(negedge clk);
    line_start = 1; line_num = ROW_W'(ACT); ext_set = 2'b01; stat_rd = 1;
    #1;
    if (status_out !== 8'h20) begin nerr++; $display("FAIL simul_preclear: got %h exp 20", status_out); end
    nchk++;
    @(posedge clk);
    model_step();
    #1;
    line_start = 0; ext_set = '0; stat_rd = 0;
    if (status_out !== 8'hC0) begin nerr++; $display("FAIL simul_set_wins: got %h exp c0", status_out); end
    nchk++;
    cyc(0, 0, '0, 1);
    if (status_out !== 8'h00) begin nerr++; $display("FAIL simul_second_ack: got %h exp 00", status_out); end
    nchk++;
  endtask

  task automatic test_enable();
    frame_ie = 0; line_ie = 0;
    cyc(0, 0, '0, 1);
    cyc(1, ACT, '0, 0);
    if (int_l !== 1'b1 || status_out !== 8'h80) begin
      nerr++; $display("FAIL enable_gated: got int_l=%b status=%h exp 1/80", int_l, status_out);
    end
    nchk++;
    @(negedge clk);
    frame_ie = 1;
    #1;
    if (int_l !== 1'b0) begin nerr++; $display("FAIL enable_raise: got %b exp 0", int_l); end
    nchk++;
    cyc(0, 0, '0, 1);
  endtask

  task automatic test_macro();
    frame_ie = 0; line_ie = 0;
    cyc(0, 0, '0, 1);
    cyc(0, 0, 2'b10, 0);
    if (status_out !== 8'h20) begin nerr++; $display("FAIL macro_status: got %h exp 20", status_out); end
    nchk++;
`ifdef VDP_IRQ_EXT_INT_EN
    if (int_l !== 1'b0) begin nerr++; $display("FAIL macro_int_l: got %b exp 0", int_l); end
`else
    if (int_l !== 1'b1) begin nerr++; $display("FAIL macro_int_l: got %b exp 1", int_l); end
`endif
    nchk++;
    cyc(0, 0, '0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      line_ie = 1'($urandom); frame_ie = 1'($urandom);
      if ($urandom_range(0, 15) == 0) line_reload = 8'($urandom_range(0, 6));
      line_start = 1'($urandom);
      line_num = ($urandom_range(0, 3) == 0) ? ROW_W'(ACT) : ROW_W'($urandom_range(0, 261));
      ext_set = ($urandom_range(0, 3) == 0) ? NEXT'($urandom) : '0;
      stat_rd = ($urandom_range(0, 5) == 0);
      #1;
      if (!rst && n > 0 && status_out !== exp_status()) begin
        nerr++; $display("FAIL rand_status_pre n=%0d: got %h exp %h", n, status_out, exp_status());
      end
      if (!rst && n > 0) nchk++;
      @(posedge clk);
      model_step();
      #1;
      if (status_out !== exp_status() || int_l !== exp_int_l()) begin
        nerr++; $display("FAIL rand_irq n=%0d: got status=%h int_l=%b exp status=%h int_l=%b", n, status_out, int_l, exp_status(), exp_int_l());
      end
      nchk++;
      if (line_cnt !== LINE_W'(m_cnt) || line_pending !== m_line) begin
        nerr++; $display("FAIL rand_line n=%0d: got cnt=%0d pend=%b exp cnt=%0d pend=%b", n, line_cnt, line_pending, m_cnt, m_line);
      end
      nchk++;
    end
    @(negedge clk);
    rst = 0; line_start = 0; ext_set = '0; stat_rd = 0;
  endtask

  initial begin
    test_reset();
    test_line_irq();
    test_frame();
    test_simultaneous();
    test_enable();
    test_macro();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
